// File: rtl/video_crop_window.sv
// video_crop_window: streaming ROI crop of a de/hs/vs pixel stream, 1 clk latency.
// VIDEO_CROP_WINDOW_STAT_EN builds per-frame resolution measurement and window-mismatch flag.
module video_crop_window #(
  parameter int PIXEL_WIDTH = 8,
  parameter int COORD_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COORD_WIDTH-1:0] cfg_x0,
  input  logic [COORD_WIDTH-1:0] cfg_y0,
  input  logic [COORD_WIDTH-1:0] cfg_w,
  input  logic [COORD_WIDTH-1:0] cfg_h,
  input  logic [PIXEL_WIDTH-1:0] di_i,
  input  logic                   de_i,
  input  logic                   hs_i,
  input  logic                   vs_i,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o,
  output logic [COORD_WIDTH-1:0] res_x_o,
  output logic [COORD_WIDTH-1:0] res_y_o,
  output logic                   err_o
);
  typedef enum logic [1:0] {WAIT_VBLANK, WAIT_FRAME, FRAME} state_t;
  state_t st;
  logic [COORD_WIDTH-1:0] x0, y0, w, h, xcnt, ycnt, xl, yn;
  logic hs_rise, vs_fall, le, start, stop, in_win, de_n;
  // hs_o/vs_o double as the previous-cycle copies for edge detection
  always_comb begin
    hs_rise = hs_i & ~hs_o;
    vs_fall = ~vs_i & vs_o;
    le = hs_rise | (vs_fall & ~hs_i);
    start = (st == WAIT_FRAME) & vs_i & ~vs_o;
    stop = (st == FRAME) & vs_fall;
    xl = xcnt + COORD_WIDTH'(de_i);
    yn = ycnt + COORD_WIDTH'(le & |xl);
    in_win = ({1'b0, xcnt} >= {1'b0, x0}) & ({1'b0, xcnt} < {1'b0, x0} + {1'b0, w})
           & ({1'b0, ycnt} >= {1'b0, y0}) & ({1'b0, ycnt} < {1'b0, y0} + {1'b0, h});
    de_n = de_i & in_win & (st == FRAME);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= WAIT_VBLANK;
      {x0, y0, w, h, xcnt, ycnt} <= '0;
      do_o <= '0;
      de_o <= 1'b0;
      hs_o <= 1'b0;
      vs_o <= 1'b0;
    end else begin
      st <= ((st == WAIT_VBLANK) && !vs_i) || stop ? WAIT_FRAME : start ? FRAME : st;
      if (start) {x0, y0, w, h} <= {cfg_x0, cfg_y0, cfg_w, cfg_h};
      xcnt <= le ? '0 : xl;
      ycnt <= start ? '0 : yn;
      de_o <= de_n;
      do_o <= de_n ? di_i : '0;
      hs_o <= hs_i;
      vs_o <= vs_i;
    end
  end
`ifdef VIDEO_CROP_WINDOW_STAT_EN
  logic [COORD_WIDTH-1:0] xmax, xm, ocnt, ol, olines, ln;
  logic bad, bn;
  // output-line statistics are taken on the input timeline, one clk ahead of de_o
  always_comb begin
    xm = (le && (xl > xmax)) ? xl : xmax;
    ol = ocnt + COORD_WIDTH'(de_n);
    ln = olines + COORD_WIDTH'(le & |ol);
    bn = bad | (le & |ol & (ol != w));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {xmax, ocnt, olines, res_x_o, res_y_o} <= '0;
      bad <= 1'b0;
      err_o <= 1'b0;
    end else begin
      xmax <= start ? '0 : xm;
      ocnt <= le ? '0 : ol;
      olines <= start ? '0 : ln;
      bad <= start ? 1'b0 : bn;
      res_x_o <= stop ? xm : res_x_o;
      res_y_o <= stop ? yn : res_y_o;
      err_o <= stop & |w & |h & ((ln != h) | bn);
    end
  end
`else
  assign res_x_o = '0;
  assign res_y_o = '0;
  assign err_o = 1'b0;
`endif
endmodule

// File: tb/tb_video_crop_window.sv
// tb_video_crop_window: randomized frame stimulus against a coordinate-level crop model.
module tb_video_crop_window;
`ifdef VIDEO_CROP_WINDOW_STAT_EN
  localparam bit STAT = 1'b1;
`else
  localparam bit STAT = 1'b0;
`endif
  logic clk = 1'b0, rst;
  logic [11:0] cfg_x0, cfg_y0, cfg_w, cfg_h, res_x_o, res_y_o;
  logic [7:0] di_i, do_o;
  logic de_i, hs_i, vs_i, de_o, hs_o, vs_o, err_o;
  int vec = 0, miss = 0, cyc = 0;
  int got_d[$], got_c[$], exp_d[$], exp_c[$], ref_d[$];
  int err_pulses, idle_bad, dly_bad;
  logic hs_prev, vs_prev, rst_q;

  video_crop_window #(.PIXEL_WIDTH(8), .COORD_WIDTH(12)) dut (
    .clk(clk), .rst(rst), .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_w(cfg_w), .cfg_h(cfg_h),
    .di_i(di_i), .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i), .do_o(do_o), .de_o(de_o),
    .hs_o(hs_o), .vs_o(vs_o), .res_x_o(res_x_o), .res_y_o(res_y_o), .err_o(err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    hs_prev <= hs_i;
    vs_prev <= vs_i;
    rst_q <= rst;
  end
  always @(negedge clk) if (rst && rst_q) begin
    if (de_o) begin
      got_d.push_back(int'(do_o));
      got_c.push_back(cyc);
    end else if (do_o !== 8'd0) idle_bad++;
    if (err_o) err_pulses++;
    if (hs_o !== hs_prev || vs_o !== vs_prev) dly_bad++;
  end

  function automatic int span(input int lo, input int len, input int lim);
    int hi;
    hi = (lo + len > lim) ? lim : lo + len;
    return hi > lo ? hi - lo : 0;
  endfunction

  task automatic drive(input logic de, input logic [7:0] d, input logic hs, input logic vs);
    @(posedge clk);
    #1;
    de_i = de; di_i = d; hs_i = hs; vs_i = vs;
  endtask

  // One frame of W x H pixels; the model lists the expected cropped pixels with their arrival cycle
  task automatic run_frame(input int W, input int H, input int per, input int rst_line,
                           input int chg_line, input int chg_w, input bit imp_end, input bit coinc,
                           input bit rnd, output int e_err, output int e_rx, output int e_ry,
                           output int snap);
    int lx0, ly0, lw, lh, ncol, outl;
    bit killed;
    logic [7:0] d;
    exp_d.delete(); exp_c.delete(); got_d.delete(); got_c.delete();
    err_pulses = 0; idle_bad = 0; dly_bad = 0; killed = 0; snap = 0;
    repeat (3) drive(0, 0, 1, 0);
    lx0 = int'(cfg_x0); ly0 = int'(cfg_y0); lw = int'(cfg_w); lh = int'(cfg_h);
    repeat (2) drive(0, 0, 1, 1);
    for (int y = 0; y < H; y++) begin
      if (y == chg_line) cfg_w = 12'(chg_w);
      drive(0, 0, 0, 1);
      if (y == rst_line) begin
        #2 rst = 1'b0;
        #1 snap = int'(de_o) + int'(do_o) + int'(hs_o) + int'(vs_o) + int'(res_x_o) + int'(res_y_o) + int'(err_o);
        #3 rst = 1'b1;
        killed = 1;
      end
      for (int x = 0; x < W; x++) begin
        repeat (per == 0 ? $urandom_range(0, 3) : per - 1) drive(0, 0, 0, 1);
        d = rnd ? 8'($urandom) : 8'(y * 16 + x);
        drive(1, d, coinc && x == W - 1, 1);
        if (!killed && x >= lx0 && x < lx0 + lw && y >= ly0 && y < ly0 + lh) begin
          exp_d.push_back(int'(d));
          exp_c.push_back(cyc + 1);
        end
      end
      if (!(imp_end && y == H - 1)) repeat (2) drive(0, 0, 1, 1);
    end
    if (imp_end) drive(0, 0, 0, 0);
    repeat (5) drive(0, 0, 1, 0);
    ncol = span(lx0, lw, W);
    outl = ncol > 0 ? span(ly0, lh, H) : 0;
    e_err = int'(STAT && !killed && lw != 0 && lh != 0 && (outl != lh || (outl > 0 && ncol != lw)));
    e_rx = (STAT && !killed) ? W : 0;
    e_ry = (STAT && !killed) ? H : 0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b0;
    #1;
    vec++; if (de_o !== 1'b0 || do_o !== 8'd0) begin miss++; $display("FAIL rst_de got %b/%0d exp 0/0", de_o, do_o); end
    vec++; if (hs_o !== 1'b0 || vs_o !== 1'b0) begin miss++; $display("FAIL rst_sync got %b%b exp 00", hs_o, vs_o); end
    vec++; if (res_x_o !== 12'd0 || res_y_o !== 12'd0 || err_o !== 1'b0) begin miss++; $display("FAIL rst_stat got %0d %0d %b exp 0 0 0", res_x_o, res_y_o, err_o); end
    de_i = 1; di_i = 8'hff; hs_i = 1; vs_i = 1;
    repeat (3) @(posedge clk);
    #1;
    vec++; if (de_o !== 1'b0 || do_o !== 8'd0 || hs_o !== 1'b0 || vs_o !== 1'b0) begin miss++; $display("FAIL rst_hold got %b %0d %b %b exp 0 0 0 0", de_o, do_o, hs_o, vs_o); end
    de_i = 0; di_i = 0; hs_i = 1; vs_i = 0;
    rst = 1'b1;
  endtask

  task automatic test_full();
    int ee, rx, ry, sn;
    cfg_x0 = 2; cfg_y0 = 3; cfg_w = 4; cfg_h = 5;
    run_frame(16, 16, 1, -1, -1, 0, 0, 0, 0, ee, rx, ry, sn);
    vec++; if (got_d.size() != 20) begin miss++; $display("FAIL full_count got %0d exp 20", got_d.size()); end
    vec++; if (got_d.size() == 0 || got_d[0] != 50) begin miss++; $display("FAIL full_first got %0d exp 50", got_d.size() ? got_d[0] : -1); end
    for (int i = 0; i < exp_d.size(); i++) begin
      vec++; if (i >= got_d.size() || got_d[i] != exp_d[i] || got_c[i] != exp_c[i]) begin miss++; $display("FAIL full_px%0d got %0d@%0d exp %0d@%0d", i, i < got_d.size() ? got_d[i] : -1, i < got_c.size() ? got_c[i] : -1, exp_d[i], exp_c[i]); end
    end
    vec++; if (int'(res_x_o) != rx || int'(res_y_o) != ry) begin miss++; $display("FAIL full_res got %0dx%0d exp %0dx%0d", res_x_o, res_y_o, rx, ry); end
    vec++; if (err_pulses != ee) begin miss++; $display("FAIL full_err got %0d exp %0d", err_pulses, ee); end
    vec++; if (idle_bad != 0 || dly_bad != 0) begin miss++; $display("FAIL full_aux got %0d/%0d exp 0/0", idle_bad, dly_bad); end
    ref_d = got_d;
  endtask

  task automatic test_gapped();
    int ee, rx, ry, sn;
    run_frame(16, 16, 4, -1, -1, 0, 0, 0, 0, ee, rx, ry, sn);
    vec++; if (got_d.size() != 20) begin miss++; $display("FAIL gap_count got %0d exp 20", got_d.size()); end
    for (int i = 0; i < exp_d.size(); i++) begin
      vec++; if (i >= got_d.size() || got_d[i] != exp_d[i] || got_c[i] != exp_c[i] || i >= ref_d.size() || got_d[i] != ref_d[i]) begin miss++; $display("FAIL gap_px%0d got %0d@%0d exp %0d@%0d", i, i < got_d.size() ? got_d[i] : -1, i < got_c.size() ? got_c[i] : -1, exp_d[i], exp_c[i]); end
    end
    vec++; if (int'(res_x_o) != rx || int'(res_y_o) != ry) begin miss++; $display("FAIL gap_res got %0dx%0d exp %0dx%0d", res_x_o, res_y_o, rx, ry); end
    vec++; if (err_pulses != ee) begin miss++; $display("FAIL gap_err got %0d exp %0d", err_pulses, ee); end
  endtask

  task automatic test_edge_clip();
    int ee, rx, ry, sn;
    cfg_x0 = 14; cfg_y0 = 3; cfg_w = 4; cfg_h = 5;
    run_frame(16, 16, 1, -1, -1, 0, 0, 0, 0, ee, rx, ry, sn);
    vec++; if (got_d.size() != 10) begin miss++; $display("FAIL clip_count got %0d exp 10", got_d.size()); end
    for (int i = 0; i < exp_d.size(); i++) begin
      vec++; if (i >= got_d.size() || got_d[i] != exp_d[i] || got_c[i] != exp_c[i]) begin miss++; $display("FAIL clip_px%0d got %0d exp %0d", i, i < got_d.size() ? got_d[i] : -1, exp_d[i]); end
    end
    vec++; if (err_pulses != (STAT ? 1 : 0) || err_pulses != ee) begin miss++; $display("FAIL clip_err got %0d exp %0d", err_pulses, ee); end
  endtask

  task automatic test_cfg_change();
    int ee, rx, ry, sn;
    cfg_x0 = 2; cfg_y0 = 3; cfg_w = 4; cfg_h = 5;
    run_frame(16, 16, 1, -1, 5, 6, 0, 0, 1, ee, rx, ry, sn);
    vec++; if (got_d.size() != 20 || got_d != exp_d) begin miss++; $display("FAIL chg_cur got %0d px exp 20", got_d.size()); end
    vec++; if (err_pulses != 0) begin miss++; $display("FAIL chg_cur_err got %0d exp 0", err_pulses); end
    run_frame(16, 16, 1, -1, -1, 0, 0, 0, 1, ee, rx, ry, sn);
    vec++; if (got_d.size() != 30 || got_d != exp_d || got_c != exp_c) begin miss++; $display("FAIL chg_next got %0d px exp 30", got_d.size()); end
    vec++; if (err_pulses != 0) begin miss++; $display("FAIL chg_next_err got %0d exp 0", err_pulses); end
  endtask

  task automatic test_reset_mid();
    int ee, rx, ry, sn;
    cfg_x0 = 2; cfg_y0 = 3; cfg_w = 4; cfg_h = 10;
    run_frame(16, 16, 1, 8, -1, 0, 0, 0, 1, ee, rx, ry, sn);
    vec++; if (sn != 0) begin miss++; $display("FAIL rmid_zero got %0d exp 0", sn); end
    vec++; if (got_d.size() != 20 || got_d != exp_d || got_c != exp_c) begin miss++; $display("FAIL rmid_px got %0d px exp 20", got_d.size()); end
    vec++; if (err_pulses != 0 || res_x_o !== 12'd0 || res_y_o !== 12'd0) begin miss++; $display("FAIL rmid_stat got %0d %0d %0d exp 0 0 0", err_pulses, res_x_o, res_y_o); end
    run_frame(16, 16, 1, -1, -1, 0, 0, 0, 1, ee, rx, ry, sn);
    vec++; if (got_d.size() != 40 || got_d != exp_d || got_c != exp_c) begin miss++; $display("FAIL rmid_next got %0d px exp 40", got_d.size()); end
    vec++; if (int'(res_x_o) != rx || int'(res_y_o) != ry || err_pulses != ee) begin miss++; $display("FAIL rmid_next_stat got %0dx%0d e%0d exp %0dx%0d e%0d", res_x_o, res_y_o, err_pulses, rx, ry, ee); end
  endtask

  task automatic test_empty();
    int ee, rx, ry, sn;
    cfg_x0 = 2; cfg_y0 = 3; cfg_w = 0; cfg_h = 5;
    run_frame(16, 16, 1, -1, -1, 0, 0, 0, 1, ee, rx, ry, sn);
    vec++; if (got_d.size() != 0) begin miss++; $display("FAIL empty_count got %0d exp 0", got_d.size()); end
    vec++; if (dly_bad != 0) begin miss++; $display("FAIL empty_sync got %0d bad cycles exp 0", dly_bad); end
    vec++; if (err_pulses != 0) begin miss++; $display("FAIL empty_err got %0d exp 0", err_pulses); end
    vec++; if (int'(res_x_o) != rx || int'(res_y_o) != ry) begin miss++; $display("FAIL empty_res got %0dx%0d exp %0dx%0d", res_x_o, res_y_o, rx, ry); end
  endtask

  task automatic test_random();
    int ee, rx, ry, sn, W, H;
    bit ie, co;
    for (int f = 0; f < 6; f++) begin
      W = $urandom_range(4, 20); H = $urandom_range(3, 12);
      cfg_x0 = 12'($urandom_range(0, W)); cfg_w = 12'($urandom_range(0, W));
      cfg_y0 = 12'($urandom_range(0, H)); cfg_h = 12'($urandom_range(0, H));
      ie = 1'($urandom); co = 1'($urandom);
      run_frame(W, H, 0, -1, -1, 0, ie, co, 1, ee, rx, ry, sn);
      vec++; if (got_d != exp_d || got_c != exp_c) begin miss++; $display("FAIL rnd%0d_px got %0d px exp %0d", f, got_d.size(), exp_d.size()); end
      vec++; if (int'(res_x_o) != rx || int'(res_y_o) != ry) begin miss++; $display("FAIL rnd%0d_res got %0dx%0d exp %0dx%0d", f, res_x_o, res_y_o, rx, ry); end
      vec++; if (err_pulses != ee) begin miss++; $display("FAIL rnd%0d_err got %0d exp %0d", f, err_pulses, ee); end
      vec++; if (idle_bad != 0 || dly_bad != 0) begin miss++; $display("FAIL rnd%0d_aux got %0d/%0d exp 0/0", f, idle_bad, dly_bad); end
    end
  endtask

  initial begin
    rst = 1'b1; de_i = 0; di_i = 0; hs_i = 1; vs_i = 0;
    cfg_x0 = 0; cfg_y0 = 0; cfg_w = 0; cfg_h = 0;
    test_reset();
    test_full();
    test_gapped();
    test_edge_clip();
    test_cfg_change();
    test_reset_mid();
    test_empty();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end
endmodule
